// File: rtl/bus_arbiter_8.sv
// bus_arbiter_8: round-robin owner selection for the shared 8-bit tri-state
// data bus. Produces a registered one-hot (or zero) grant/oe set, inserts one
// dead turnaround cycle between owners and bounds the hold time of an owner
// while other sources are waiting.
module bus_arbiter_8 #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic [N-1:0] oe,
   output logic [2:0]   owner,
   output logic         busy
);

   localparam int RW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] TURN  = 2'd2;

   logic [1:0]    state_reg, state_next;
   logic [N-1:0]  grant_reg, grant_next;
   logic [2:0]    owner_reg, owner_next;
   logic [HW-1:0] hcnt_reg, hcnt_next;
   logic [RW-1:0] rr_reg, rr_next;

   logic          found;
   logic [RW-1:0] win;
   logic [RW-1:0] rr_adv;
   logic [N-1:0]  win_onehot;
   logic          owner_req;
   logic          others_req;

   genvar gi;

   // Owner still requesting / anyone else waiting (grant_reg is one-hot or zero)
   assign owner_req  = |(req & grant_reg);
   assign others_req = |(req & ~grant_reg);

   // Round-robin search: first set request starting at rr, wrapping modulo N
   always_comb begin : search
      int idx;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(rr_reg) + i;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = RW'(idx);
         end
      end
   end

   // Pointer moves just past the winner so the winner becomes lowest priority
   assign rr_adv = (win == RW'(N - 1)) ? '0 : win + 1'b1;

   for (gi = 0; gi < N; gi++) begin : g_dec
      assign win_onehot[gi] = (win == RW'(gi));
   end

   // Next-state logic for IDLE / GRANT / TURN
   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      owner_next = owner_reg;
      hcnt_next  = hcnt_reg;
      rr_next    = rr_reg;
      case (state_reg)
         IDLE, TURN: begin
            // TURN behaves like IDLE for selection; its only job is the dead cycle
            if (found) begin
               state_next = GRANT;
               grant_next = win_onehot;
               owner_next = 3'(win);
               hcnt_next  = HW'(1);
               rr_next    = rr_adv;
            end else begin
               state_next = IDLE;
               grant_next = '0;
               owner_next = '0;
               hcnt_next  = '0;
            end
         end
         GRANT: begin
            if (!owner_req || (hcnt_reg == HW'(MAX_HOLD) && others_req)) begin
               // Release or preemption: drop all enables for one cycle
               state_next = TURN;
               grant_next = '0;
               owner_next = '0;
               hcnt_next  = '0;
            end else if (hcnt_reg != HW'(MAX_HOLD)) begin
               hcnt_next = hcnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
            owner_next = '0;
            hcnt_next  = '0;
         end
      endcase
   end

   // State registers; reset clears enables immediately so the bus floats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         grant_reg <= '0;
         owner_reg <= '0;
         hcnt_reg  <= '0;
         rr_reg    <= '0;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         owner_reg <= owner_next;
         hcnt_reg  <= hcnt_next;
         rr_reg    <= rr_next;
      end
   end

   assign grant = grant_reg;
   assign oe    = grant_reg;
   assign owner = owner_reg;
   assign busy  = |grant_reg;

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Directed bench for bus_arbiter_8 (N=4, MAX_HOLD=8) with a scoreboard queue
// of expected grant/owner values per clock step.
module tb_bus_arbiter_8;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] grant;
   logic [3:0] oe;
   logic [2:0] owner;
   logic       busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] g;
      logic [2:0] o;
      string      tag;
   } exp_t;

   exp_t sb[$];

   bus_arbiter_8 #(.N(4), .MAX_HOLD(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .grant (grant),
      .oe    (oe),
      .owner (owner),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Invariants every cycle: one-hot/zero grant, oe mirrors grant
   always @(negedge clk) begin
      checks++;
      assert ($onehot0(grant)) else begin
         errors++;
         $error("FAIL onehot grant=%b required=onehot0", grant);
      end
      checks++;
      assert (oe === grant) else begin
         errors++;
         $error("FAIL oe_eq_grant oe=%b required=%b", oe, grant);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check_out(input exp_t e);
      checks++;
      assert (grant === e.g) else begin
         errors++;
         $error("FAIL %s grant=%b required=%b", e.tag, grant, e.g);
      end
      checks++;
      assert (oe === e.g) else begin
         errors++;
         $error("FAIL %s oe=%b required=%b", e.tag, oe, e.g);
      end
      checks++;
      assert (owner === e.o) else begin
         errors++;
         $error("FAIL %s owner=%0d required=%0d", e.tag, owner, e.o);
      end
      checks++;
      assert (busy === (e.g != 4'b0000)) else begin
         errors++;
         $error("FAIL %s busy=%b required=%b", e.tag, busy, (e.g != 4'b0000));
      end
   endtask

   // Drive req for one edge, push expected post-edge outputs, pop and compare
   task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [2:0] eo,
                       input string tag);
      exp_t e;
      req = r;
      sb.push_back('{g: eg, o: eo, tag: tag});
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL %s scoreboard empty=1 required=0", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check_out(e);
         $display("step %-10s req=%b grant=%b owner=%0d busy=%b", tag, r, grant, owner, busy);
      end
   endtask

   task automatic check_reset(input string tag);
      exp_t e;
      e = '{g: 4'b0000, o: 3'd0, tag: tag};
      check_out(e);
      $display("reset %-10s grant=%b oe=%b owner=%0d busy=%b", tag, grant, oe, owner, busy);
   endtask

   initial begin
      int o;
      logic [3:0] oh;
      rst_n = 1'b0;
      req   = 4'b1111;
      #3;
      check_reset("rst_vals");
      @(posedge clk);
      #1;
      check_reset("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      #4;
      // first edge after reset grants source 0 (rr restarts at 0)
      step(4'b1111, 4'b0001, 3'd0, "rst_first");
      step(4'b0000, 4'b0000, 3'd0, "rst_turn");
      step(4'b0000, 4'b0000, 3'd0, "rst_idle");

      // single requester for 5 cycles, then turnaround and idle
      for (int i = 0; i < 5; i++) step(4'b0100, 4'b0100, 3'd2, "single");
      step(4'b0000, 4'b0000, 3'd0, "single_trn");
      step(4'b0000, 4'b0000, 3'd0, "single_idl");

      // lone requester held 20 cycles: no forced release
      for (int i = 0; i < 20; i++) step(4'b0100, 4'b0100, 3'd2, "lone_hold");
      step(4'b0000, 4'b0000, 3'd0, "lone_trn");
      step(4'b0000, 4'b0000, 3'd0, "lone_idl");

      // reset to restart the pointer at 0, then all request continuously
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      #4;
      for (int k = 0; k < 5; k++) begin
         o  = k % 4;
         oh = 4'b0001 << o;
         for (int c = 0; c < 8; c++) step(4'b1111, oh, 3'(o), "rr_hold");
         if (k < 4) step(4'b1111, 4'b0000, 3'd0, "rr_turn");
      end
      step(4'b0000, 4'b0000, 3'd0, "rr_end_trn");
      step(4'b0000, 4'b0000, 3'd0, "rr_end_idl");

      // voluntary release by source 1 after 3 cycles; source 2 skipped
      for (int i = 0; i < 3; i++) step(4'b1010, 4'b0010, 3'd1, "vol_own1");
      step(4'b1000, 4'b0000, 3'd0, "vol_turn");
      step(4'b1000, 4'b1000, 3'd3, "vol_grant3");

      // owner 3 releases; in TURN req=1001 wraps the search to source 0
      step(4'b0001, 4'b0000, 3'd0, "wrap_turn");
      step(4'b1001, 4'b0001, 3'd0, "wrap_grant0");
      step(4'b0000, 4'b0000, 3'd0, "wrap_trn");
      step(4'b0000, 4'b0000, 3'd0, "wrap_idl");

      // reset pulsed mid-grant: enables drop without a clock edge
      step(4'b0010, 4'b0010, 3'd1, "mid_grant");
      #1;
      rst_n = 1'b0;
      #1;
      check_reset("mid_rst");
      req = 4'b0110;
      #1;
      rst_n = 1'b1;
      step(4'b0110, 4'b0010, 3'd1, "post_rst");
      step(4'b0110, 4'b0010, 3'd1, "post_rst2");
      step(4'b0000, 4'b0000, 3'd0, "post_trn");

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain size=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
